// File: rtl/riscv_32i_defs_pkg.sv
// Shared RV32I widths and the register-file reader state encoding.
package riscv_32i_defs_pkg;

    localparam int XLEN           = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND,
        ST_CSUM,
        ST_DONE
    } reg_file_reader_state_t;

endpackage

// File: rtl/reg_file_reader.sv
// Register-file dump engine: walks first_reg..last_reg through one read port and
// streams each value on a valid/ready port. REG_FILE_READER_CSUM_EN appends an XOR checksum beat.
module reg_file_reader
    import riscv_32i_defs_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [REG_ADDR_WIDTH-1:0] first_reg,
    input  logic [REG_ADDR_WIDTH-1:0] last_reg,
    output logic [REG_ADDR_WIDTH-1:0] rd_reg,
    input  logic [XLEN-1:0]           rd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_data,
    output logic [REG_ADDR_WIDTH-1:0] out_reg,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);

`ifdef REG_FILE_READER_CSUM_EN
    localparam bit                     CSUM_EN       = 1'b1;
    localparam reg_file_reader_state_t ST_AFTER_LAST = ST_CSUM;
`else
    localparam bit                     CSUM_EN       = 1'b0;
    localparam reg_file_reader_state_t ST_AFTER_LAST = ST_DONE;
`endif

    reg_file_reader_state_t    r_state;
    reg_file_reader_state_t    w_next_state;
    logic [REG_ADDR_WIDTH-1:0] r_idx;
    logic [REG_ADDR_WIDTH-1:0] r_last;
    logic [XLEN-1:0]           r_out_data;
    logic [REG_ADDR_WIDTH-1:0] r_out_reg;
    logic                      r_out_last;
    logic [XLEN-1:0]           r_csum;
    logic                      w_handshake;
    logic                      w_idx_at_last;
    logic                      w_range_empty;
    logic                      w_abort;

    assign w_handshake   = out_valid && out_ready;
    assign w_idx_at_last = (r_idx == r_last);
    assign w_range_empty = (first_reg > last_reg);
    assign w_abort       = abort && (r_state inside {ST_FETCH, ST_SEND, ST_CSUM});

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // NOTE: the default assignment first keeps this block purely combinational (no latch).
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = w_range_empty ? ST_AFTER_LAST : ST_FETCH;
            end
            ST_FETCH: w_next_state = ST_SEND;
            ST_SEND: begin
                if (w_handshake) w_next_state = w_idx_at_last ? ST_AFTER_LAST : ST_FETCH;
            end
            ST_CSUM: begin
                if (w_handshake) w_next_state = ST_DONE;
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
        // Abort wins over a handshake in the same cycle.
        if (w_abort) w_next_state = ST_IDLE;
    end

    always_comb begin
        rd_reg    = r_idx;
        out_valid = (r_state == ST_SEND) || (r_state == ST_CSUM);
        out_data  = r_out_data;
        out_reg   = r_out_reg;
        out_last  = r_out_last;
        busy      = (r_state != ST_IDLE);
        done      = (r_state == ST_DONE);
    end

    // NOTE: every datapath flop is reset; there is no memory here, so the reset is cheap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_last     <= '0;
            r_out_data <= '0;
            r_out_reg  <= '0;
            r_out_last <= 1'b0;
            r_csum     <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_idx  <= first_reg;
                        r_last <= last_reg;
                        r_csum <= '0;
                        // An empty range still emits one checksum beat of zero.
                        if (CSUM_EN && w_range_empty) begin
                            r_out_data <= '0;
                            r_out_reg  <= '0;
                            r_out_last <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    r_out_data <= rd_data;
                    r_out_reg  <= r_idx;
                    r_out_last <= w_idx_at_last && !CSUM_EN;
                end
                ST_SEND: begin
                    if (w_handshake && !w_abort) begin
                        r_csum <= r_csum ^ r_out_data;
                        // Compare before incrementing so a 0..31 walk never wraps.
                        if (w_idx_at_last) begin
                            if (CSUM_EN) begin
                                r_out_data <= r_csum ^ r_out_data;
                                r_out_reg  <= '0;
                                r_out_last <= 1'b1;
                            end
                        end else begin
                            r_idx <= r_idx + REG_ADDR_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_reader.sv
// Scoreboard bench for reg_file_reader; builds with or without REG_FILE_READER_CSUM_EN.
module tb_reg_file_reader;
    import riscv_32i_defs_pkg::*;

`ifdef REG_FILE_READER_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rg;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  first_reg = '0;
    logic [4:0]  last_reg = '0;
    logic [4:0]  rd_reg;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_reg;
    logic        out_last;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    reg_file_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .rd_reg    (rd_reg),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_reg   (out_reg),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    // Register file stand-in: x0 reads 0, writes land on the clock edge.
    logic [31:0] rf [32];
    logic [31:0] exp_rf [32] = '{default: 32'h0};
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;

    always @(posedge clk) if (wr_en && wr_addr != 5'd0) rf[wr_addr] <= wr_data;
    assign rd_data = (rd_reg == 5'd0) ? 32'h0 : rf[rd_reg];

    int    n_checks = 0;
    int    n_errors = 0;
    beat_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every accepted beat is compared against the head of the queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !abort) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_beat: got reg %0d data 0x%08h, expected no beat",
                         out_reg, out_data);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("beat_data", out_data, e.data);
                check("beat_reg", 32'(out_reg), 32'(e.rg));
                check("beat_last", 32'(out_last), 32'(e.last));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pat(input logic [4:0] r);
        return {r, 3'b101, r, 3'b010, 16'hBEEF ^ {11'b0, r}};
    endfunction

    task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
        wr_en     = 1'b1;
        wr_addr   = r;
        wr_data   = v;
        exp_rf[r] = v;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic push_range(input logic [4:0] f, input logic [4:0] l);
        logic [31:0] x;
        x = '0;
        for (int i = int'(f); i <= int'(l); i++) begin
            logic [31:0] d;
            beat_t       b;
            d = (i == 0) ? 32'h0 : exp_rf[i];
            b.data = d;
            b.rg   = 5'(i);
            b.last = (i == int'(l)) && !CSUM;
            exp_q.push_back(b);
            x ^= d;
        end
        if (CSUM) exp_q.push_back('{data: x, rg: 5'd0, last: 1'b1});
    endtask

    // Counts cycles until done; start is dropped after the first edge.
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
            start = 1'b0;
            if (cyc == 1) check("busy_rise", 32'(busy), 32'd1);
        end while (done !== 1'b1 && cyc < 400);
    endtask

    task automatic run_dump(input string name, input logic [4:0] f, input logic [4:0] l);
        int cyc;
        int n;
        n = (l >= f) ? int'(l) - int'(f) + 1 : 0;
        push_range(f, l);
        first_reg = f;
        last_reg  = l;
        out_ready = 1'b1;
        start     = 1'b1;
        wait_done(cyc);
        check({name, "_done_cycles"}, 32'(cyc), 32'(2 * n + 1 + int'(CSUM)));
        check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
        tick();
        check({name, "_done_pulse"}, 32'(done), 32'd0);
        check({name, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, out_data, 32'd0);
        check({tag, "_out_reg"}, 32'(out_reg), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_rd_reg"}, 32'(rd_reg), 32'd0);
    endtask

    initial begin
        int cyc;
        tick();
        tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        for (int r = 1; r < 32; r++) write_reg(5'(r), pat(5'(r)));
        write_reg(5'd1, 32'h11);
        write_reg(5'd2, 32'h22);
        write_reg(5'd3, 32'h33);
        write_reg(5'd5, 32'hDEADBEEF);

        run_dump("basic", 5'd1, 5'd3);
        run_dump("full", 5'd0, 5'd31);

        // Back-pressure on the x5 beat for five cycles.
        push_range(5'd5, 5'd5);
        first_reg = 5'd5;
        last_reg  = 5'd5;
        out_ready = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", out_data, 32'hDEADBEEF);
            check("bp_reg", 32'(out_reg), 32'd5);
            tick();
        end
        out_ready = 1'b1;
        wait_done(cyc);
        check("bp_accept_cycles", 32'(cyc), 32'(1 + int'(CSUM)));
        check("bp_queue_drained", 32'(exp_q.size()), 32'd0);
        tick();

        // Write on the FETCH edge of x4: old value is streamed.
        push_range(5'd4, 5'd4);
        first_reg = 5'd4;
        last_reg  = 5'd4;
        start     = 1'b1;
        tick();
        start = 1'b0;
        write_reg(5'd4, 32'hAAAA);
        wait_done(cyc);
        check("haz_same_edge_cycles", 32'(cyc), 32'(1 + int'(CSUM)));
        check("haz_same_edge_drained", 32'(exp_q.size()), 32'd0);
        tick();
        write_reg(5'd4, pat(5'd4));

        // Write one edge earlier (with start): new value is streamed.
        wr_en     = 1'b1;
        wr_addr   = 5'd4;
        wr_data   = 32'hAAAA;
        exp_rf[4] = 32'hAAAA;
        push_range(5'd4, 5'd4);
        start = 1'b1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        wait_done(cyc);
        check("haz_early_cycles", 32'(cyc), 32'(2 + int'(CSUM)));
        check("haz_early_drained", 32'(exp_q.size()), 32'd0);
        tick();

        // Abort during SEND of the second beat; only x1 is accepted.
        exp_q.push_back('{data: 32'h11, rg: 5'd1, last: 1'b0});
        first_reg = 5'd1;
        last_reg  = 5'd3;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("abort_pre_valid", 32'(out_valid), 32'd1);
        check("abort_pre_reg", 32'(out_reg), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_drained", 32'(exp_q.size()), 32'd0);
        run_dump("restart", 5'd2, 5'd3);

        run_dump("empty", 5'd5, 5'd2);

        // Reset while a beat is pending.
        first_reg = 5'd5;
        last_reg  = 5'd5;
        out_ready = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("rst_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
